// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and hazard controller for a 5-stage in-order pipeline.
// It tracks the EX/MEM/WB producers and drives stall, bubble and flush controls.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              ex_branch_taken,
    input  logic              stall_ext,
    output logic [1:0]        fwd_rs1_sel,
    output logic [1:0]        fwd_rs2_sel,
    output logic              stall_if_id,
    output logic              bubble_ex,
    output logic              flush_if_id,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              is_load;
    } slot_t;

    slot_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [1:0]        sel1_q, sel1_d, sel2_q, sel2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_use;
    slot_t             id_slot;

    // Register x0 never carries a produced value, so it never matches.
    function automatic logic hit(slot_t s, logic [REG_AW-1:0] rs, logic use_rs);
        return use_rs && s.valid && s.reg_write && (s.rd != '0) && (s.rd == rs);
    endfunction

    function automatic logic [1:0] pick(slot_t ex_s, slot_t mem_s,
                                        logic [REG_AW-1:0] rs, logic use_rs);
        if (hit(ex_s, rs, use_rs))       return 2'b01;
        else if (hit(mem_s, rs, use_rs)) return 2'b10;
        else                             return 2'b00;
    endfunction

    always_comb begin
        id_slot = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, is_load: id_is_load};
        load_use = id_valid && ex_q.is_load &&
                   (hit(ex_q, id_rs1, id_use_rs1) || hit(ex_q, id_rs2, id_use_rs2));
    end

    always_comb begin
        stall_if_id = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        if (stall_ext) begin
            stall_if_id = 1'b1;
        end else if (ex_branch_taken) begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
        end else if (load_use) begin
            stall_if_id = 1'b1;
            bubble_ex   = 1'b1;
        end
    end

    // A frozen cycle keeps everything; otherwise the slots shift and EX takes ID or a bubble.
    always_comb begin
        ex_d   = ex_q;
        mem_d  = mem_q;
        wb_d   = wb_q;
        sel1_d = sel1_q;
        sel2_d = sel2_q;
        cnt_d  = cnt_q;
        if (!stall_ext) begin
            mem_d = ex_q;
            wb_d  = mem_q;
            if (bubble_ex) begin
                ex_d   = '0;
                sel1_d = 2'b00;
                sel2_d = 2'b00;
            end else begin
                ex_d   = id_slot;
                sel1_d = pick(ex_q, mem_q, id_rs1, id_use_rs1);
                sel2_d = pick(ex_q, mem_q, id_rs2, id_use_rs2);
            end
            if (load_use && !ex_branch_taken && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q   <= '0;
            mem_q  <= '0;
            wb_q   <= '0;
            sel1_q <= 2'b00;
            sel2_q <= 2'b00;
            cnt_q  <= '0;
        end else begin
            ex_q   <= ex_d;
            mem_q  <= mem_d;
            wb_q   <= wb_d;
            sel1_q <= sel1_d;
            sel2_q <= sel2_d;
            cnt_q  <= cnt_d;
        end
    end

    assign fwd_rs1_sel = sel1_q;
    assign fwd_rs2_sel = sel2_q;
    assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: a vector table for the main sequence plus
// hand-written sequences for counter saturation and reset in the middle of a stall.
module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_reg_write, id_is_load;
    logic        ex_branch_taken, stall_ext;
    logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
    logic        stall_if_id, bubble_ex, flush_if_id;
    logic [15:0] stall_cnt;
    logic [1:0]  sat_sel1, sat_sel2;
    logic        sat_stall, sat_bubble, sat_flush;
    logic [2:0]  sat_cnt;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .stall_ext(stall_ext),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .stall_if_id(stall_if_id), .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
        .stall_cnt(stall_cnt)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(3)) dutSat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .stall_ext(stall_ext),
        .fwd_rs1_sel(sat_sel1), .fwd_rs2_sel(sat_sel2),
        .stall_if_id(sat_stall), .bubble_ex(sat_bubble), .flush_if_id(sat_flush),
        .stall_cnt(sat_cnt)
    );

    typedef struct {
        int valid, rs1, rs2, use1, use2, rd, rw, ld, br, sx;
        int eStall, eBubble, eFlush, eSel1, eSel2, eCnt;
    } vec_t;

    vec_t vecs[24];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        id_valid        = (v.valid != 0);
        id_rs1          = 5'(v.rs1);
        id_rs2          = 5'(v.rs2);
        id_use_rs1      = (v.use1 != 0);
        id_use_rs2      = (v.use2 != 0);
        id_rd           = 5'(v.rd);
        id_reg_write    = (v.rw != 0);
        id_is_load      = (v.ld != 0);
        ex_branch_taken = (v.br != 0);
        stall_ext       = (v.sx != 0);
    endtask

    task automatic checkAll(input string tag, input int eStall, input int eBubble,
                            input int eFlush, input int eSel1, input int eSel2, input int eCnt);
        checkOutput({tag, " stall_if_id"}, int'(stall_if_id), eStall);
        checkOutput({tag, " bubble_ex"},   int'(bubble_ex),   eBubble);
        checkOutput({tag, " flush_if_id"}, int'(flush_if_id), eFlush);
        checkOutput({tag, " fwd_rs1_sel"}, int'(fwd_rs1_sel), eSel1);
        checkOutput({tag, " fwd_rs2_sel"}, int'(fwd_rs2_sel), eSel2);
        checkOutput({tag, " stall_cnt"},   int'(stall_cnt),   eCnt);
        checkOutput({tag, " sat_cnt"},     int'(sat_cnt),     (eCnt > 7) ? 7 : eCnt);
    endtask

    vec_t nop, lw7;
    int   expCnt;

    initial begin
        //         valid rs1 rs2 u1 u2 rd rw ld br sx | stall bub fl s1 s2 cnt
        vecs[0]  = '{1, 1, 2, 1, 1, 5, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 5, 3, 1, 1, 6, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 9, 5, 1, 1, 8, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0};
        vecs[3]  = '{1, 5, 5, 1, 1, 9, 1, 0, 0, 0,   0, 0, 0, 0, 2, 0};
        vecs[4]  = '{1, 9, 8, 1, 1, 10, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        vecs[5]  = '{1, 1, 2, 1, 1, 10, 1, 0, 0, 0,  0, 0, 0, 1, 2, 0};
        vecs[6]  = '{1, 10, 10, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[7]  = '{1, 1, 2, 1, 1, 0, 1, 1, 0, 0,   0, 0, 0, 1, 1, 0};
        vecs[8]  = '{1, 0, 0, 1, 1, 12, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        vecs[9]  = '{1, 12, 12, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{1, 1, 0, 1, 0, 7, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0};
        vecs[11] = '{1, 7, 7, 1, 1, 14, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0};
        vecs[12] = '{1, 7, 7, 1, 1, 14, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 2, 1};
        vecs[14] = '{1, 1, 0, 1, 0, 7, 1, 1, 0, 0,   0, 0, 0, 0, 0, 1};
        vecs[15] = '{1, 7, 0, 1, 0, 14, 1, 0, 1, 0,  0, 1, 1, 0, 0, 1};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1};
        vecs[17] = '{1, 1, 0, 1, 0, 7, 1, 1, 0, 0,   0, 0, 0, 0, 0, 1};
        vecs[18] = '{1, 7, 7, 1, 1, 14, 1, 0, 1, 1,  1, 0, 0, 0, 0, 1};
        vecs[19] = '{1, 7, 7, 1, 1, 14, 1, 0, 0, 1,  1, 0, 0, 0, 0, 1};
        vecs[20] = '{1, 7, 7, 1, 1, 14, 1, 0, 0, 0,  1, 1, 0, 0, 0, 1};
        vecs[21] = '{1, 7, 7, 1, 1, 14, 1, 0, 0, 0,  0, 0, 0, 0, 0, 2};
        vecs[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 2, 2, 2};
        vecs[23] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 2, 2};

        nop = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        lw7 = '{1, 7, 0, 1, 0, 7, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0};

        // Asynchronous reset asserted well away from any clock edge.
        rst_n = 1'b1;
        applyStimulus(nop);
        #2 rst_n = 1'b0;
        #1 checkAll("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #2;
            checkAll($sformatf("v%0d", i), vecs[i].eStall, vecs[i].eBubble, vecs[i].eFlush,
                     vecs[i].eSel1, vecs[i].eSel2, vecs[i].eCnt);
        end

        // A load that reads its own destination stalls on every second cycle.
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            applyStimulus(lw7);
            #2;
            expCnt = 2 + (i - 1) / 2;
            checkOutput($sformatf("sat%0d stall_if_id", i), int'(stall_if_id), (i % 2 == 0) ? 1 : 0);
            checkOutput($sformatf("sat%0d stall_cnt", i), int'(stall_cnt), expCnt);
            checkOutput($sformatf("sat%0d sat_cnt", i), int'(sat_cnt), (expCnt > 7) ? 7 : expCnt);
        end
        @(negedge clk);
        applyStimulus(lw7);
        #2;
        checkOutput("after sat stall_cnt", int'(stall_cnt), 10);
        checkOutput("after sat sat_cnt", int'(sat_cnt), 7);
        checkOutput("after sat stall_if_id", int'(stall_if_id), 0);

        // Reset pulsed while a load-use stall is being signalled.
        @(negedge clk);
        applyStimulus(lw7);
        #2;
        checkOutput("prerst stall_if_id", int'(stall_if_id), 1);
        checkOutput("prerst fwd_rs1_sel", int'(fwd_rs1_sel), 2);
        #1 rst_n = 1'b0;
        #1;
        checkAll("midrst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(lw7);
        #2;
        checkOutput("postrst stall_if_id", int'(stall_if_id), 0);
        checkOutput("postrst bubble_ex", int'(bubble_ex), 0);
        checkOutput("postrst stall_cnt", int'(stall_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
